// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared types, constants and the min-metric state selector
// for the K=3 Viterbi traceback slice.
`default_nettype none

package viterbi_pkg;

  localparam int NUM_STATES = 4;
  localparam int DEC_W      = 4;
  localparam int PM_MAX_W   = 32;

  typedef logic [1:0] state_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    TRACE = 2'd1,
    OUT   = 2'd2
  } fsm_e;

  // Index of the smallest metric; strict compares keep the lower index on ties.
  function automatic state_t best_state(input logic [PM_MAX_W-1:0] p0,
                                        input logic [PM_MAX_W-1:0] p1,
                                        input logic [PM_MAX_W-1:0] p2,
                                        input logic [PM_MAX_W-1:0] p3);
    logic [PM_MAX_W-1:0] m01;
    logic [PM_MAX_W-1:0] m23;
    state_t              b01;
    state_t              b23;
    b01 = (p1 < p0) ? 2'd1 : 2'd0;
    m01 = (p1 < p0) ? p1 : p0;
    b23 = (p3 < p2) ? 2'd3 : 2'd2;
    m23 = (p3 < p2) ? p3 : p2;
    return (m23 < m01) ? b23 : b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/viterbi_traceback_min4.sv
// viterbi_min4: combinational 4-way minimum-index selector, lowest index on tie.
`default_nettype none

module viterbi_min4
  import viterbi_pkg::*;
#(
  parameter int PM_W = 4
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [PM_W-1:0] pm2_i,
  input  logic [PM_W-1:0] pm3_i,
  output state_t          best_o
);

  assign best_o = best_state(PM_MAX_W'(pm0_i), PM_MAX_W'(pm1_i),
                             PM_MAX_W'(pm2_i), PM_MAX_W'(pm3_i));

endmodule

`default_nettype wire

// File: rtl/viterbi_traceback.sv
// viterbi_traceback: survivor memory plus block traceback for the 4-state decoder;
// decoded bits leave in forward order over a valid/ready port.
`default_nettype none

module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int PM_W      = 4,
  parameter int BLOCK_LEN = 8,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DEC_W-1:0] dec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PM_W-1:0]  pm0,
  input  logic [PM_W-1:0]  pm1,
  input  logic [PM_W-1:0]  pm2,
  input  logic [PM_W-1:0]  pm3,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int               IDX_W    = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

  fsm_e                 state_q;
  logic [CNT_W-1:0]     wr_cnt_q;
  logic [CNT_W-1:0]     tb_idx_q;
  logic [CNT_W-1:0]     rd_idx_q;
  logic [CNT_W-1:0]     rd_idx_d;
  state_t               cur_q;
  state_t               best;
  logic [BLOCK_LEN-1:0] out_buf_q;
  logic [DEC_W-1:0]     mem_q [BLOCK_LEN];
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 out_bit_q;
  logic                 out_last_q;
  logic                 accept;
  logic                 mem_bit;

  viterbi_min4 #(.PM_W(PM_W)) u_min4 (
    .pm0_i  (pm0),
    .pm1_i  (pm1),
    .pm2_i  (pm2),
    .pm3_i  (pm3),
    .best_o (best)
  );

  assign accept   = in_valid && in_ready_q;
  assign rd_idx_d = rd_idx_q + CNT_W'(1);
  assign mem_bit  = mem_q[tb_idx_q[IDX_W-1:0]][cur_q];

  // Decision RAM carries no reset; a block is always fully rewritten before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_cnt_q[IDX_W-1:0]] <= dec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      wr_cnt_q    <= '0;
      tb_idx_q    <= '0;
      rd_idx_q    <= '0;
      cur_q       <= '0;
      out_buf_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            if (wr_cnt_q == LAST_IDX) begin
              cur_q      <= best;
              tb_idx_q   <= LAST_IDX;
              in_ready_q <= 1'b0;
              state_q    <= TRACE;
            end else begin
              wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end
          end
        end
        TRACE: begin
          out_buf_q[tb_idx_q[IDX_W-1:0]] <= cur_q[1];
          cur_q                          <= {cur_q[0], mem_bit};
          if (tb_idx_q == '0) begin
            rd_idx_q <= '0;
            state_q  <= OUT;
          end else begin
            tb_idx_q <= tb_idx_q - CNT_W'(1);
          end
        end
        OUT: begin
          // First OUT cycle loads the output register; afterwards one bit per handshake.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_bit_q   <= out_buf_q[rd_idx_q[IDX_W-1:0]];
            out_last_q  <= (rd_idx_q == LAST_IDX);
          end else if (out_ready) begin
            if (rd_idx_q == LAST_IDX) begin
              out_valid_q <= 1'b0;
              out_bit_q   <= 1'b0;
              out_last_q  <= 1'b0;
              rd_idx_q    <= '0;
              wr_cnt_q    <= '0;
              in_ready_q  <= 1'b1;
              state_q     <= FILL;
            end else begin
              rd_idx_q   <= rd_idx_d;
              out_bit_q  <= out_buf_q[rd_idx_d[IDX_W-1:0]];
              out_last_q <= (rd_idx_d == LAST_IDX);
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;

endmodule

`default_nettype wire

// File: tb/tb_viterbi_traceback.sv
// tb_viterbi_traceback: randomized self-checking bench against a trellis-walk reference.
`default_nettype none

module tb_viterbi_traceback;

  localparam int BL = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] dec;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] pm0, pm1, pm2, pm3;
  logic       out_bit;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc   = 0;

  logic [3:0] blk_dec [BL];
  logic [3:0] blk_pm  [4];

  viterbi_traceback #(.PM_W(4), .BLOCK_LEN(BL), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .dec       (dec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pm0       (pm0),
    .pm1       (pm1),
    .pm2       (pm2),
    .pm3       (pm3),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: pick the minimum metric (lowest index on ties), then walk the
  // trellis backwards; bit t of the result is the decoded bit of step t.
  function automatic logic [BL-1:0] ref_decode();
    logic [BL-1:0] r;
    logic [1:0]    s;
    logic [3:0]    dt;
    int            best;
    best = 0;
    for (int i = 1; i < 4; i++)
      if (blk_pm[i] < blk_pm[best]) best = i;
    s = 2'(best);
    for (int t = BL - 1; t >= 0; t--) begin
      r[t] = s[1];
      dt   = blk_dec[t];
      s    = {s[0], dt[s]};
    end
    return r;
  endfunction

  task automatic randomize_block();
    for (int i = 0; i < BL; i++) blk_dec[i] = 4'($urandom);
    for (int i = 0; i < 4; i++)  blk_pm[i]  = 4'($urandom);
  endtask

  task automatic send_block(input bit stall, input bit junk);
    int n;
    for (int i = 0; i < BL; i++) begin
      if (stall && (i % 2 == 1)) begin
        in_valid = 1'b0;
        dec      = 4'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      dec      = blk_dec[i];
      if (i == BL - 1) begin
        pm0 = blk_pm[0]; pm1 = blk_pm[1]; pm2 = blk_pm[2]; pm3 = blk_pm[3];
      end else begin
        pm0 = 4'($urandom); pm1 = 4'($urandom); pm2 = 4'($urandom); pm3 = 4'($urandom);
      end
      n = 0;
      while (!in_ready && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 100) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    acc      = cyc;
    in_valid = junk;
    dec      = 4'($urandom);
    pm0 = 4'($urandom); pm1 = 4'($urandom); pm2 = 4'($urandom); pm3 = 4'($urandom);
  endtask

  task automatic collect(input logic [BL-1:0] exp, input int nbits, input bit bp);
    int   n;
    logic hb, hl;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
    chk("latency", 32'(cyc - acc), 32'(BL + 1));
    for (int k = 0; k < nbits; k++) begin
      if (bp && k == 3) begin
        out_ready = 1'b0;
        hb = out_bit;
        hl = out_last;
        for (int w = 0; w < 5; w++) begin
          @(posedge clk); #1;
          chk("bp_valid", {31'd0, out_valid}, 32'd1);
          chk("bp_bit", {31'd0, out_bit}, {31'd0, hb});
          chk("bp_last", {31'd0, out_last}, {31'd0, hl});
          chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
      end
      chk("bit", {31'd0, out_bit}, {31'd0, exp[k]});
      chk("valid", {31'd0, out_valid}, 32'd1);
      chk("last", {31'd0, out_last}, (k == BL - 1) ? 32'd1 : 32'd0);
      chk("in_ready_out", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      if (k == BL - 1) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    if (nbits == BL) begin
      chk("valid_end", {31'd0, out_valid}, 32'd0);
      chk("in_ready_end", {31'd0, in_ready}, 32'd1);
    end
  endtask

  task automatic run_block(input bit stall, input bit junk, input bit bp);
    logic [BL-1:0] e;
    e = ref_decode();
    send_block(stall, junk);
    collect(e, BL, bp);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; dec = '0; out_ready = 1'b0;
    pm0 = '0; pm1 = '0; pm2 = '0; pm3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_bit", {31'd0, out_bit}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed message 1,0,1,1,0,0,0,0
    blk_dec = '{4'h0, 4'h0, 4'h4, 4'h0, 4'h2, 4'h1, 4'h0, 4'h0};
    blk_pm  = '{4'd0, 4'd3, 4'd4, 4'd5};
    send_block(1'b0, 1'b0);
    collect(8'b0000_1101, BL, 1'b0);

    // All-zero decisions, metric tie between states 1 and 3
    blk_dec = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    blk_pm  = '{4'd7, 4'd2, 4'd9, 4'd2};
    run_block(1'b0, 1'b0, 1'b0);

    randomize_block();
    run_block(1'b0, 1'b0, 1'b1);

    randomize_block();
    run_block(1'b1, 1'b1, 1'b0);
    randomize_block();
    run_block(1'b0, 1'b0, 1'b0);

    // Reset in the middle of output
    randomize_block();
    send_block(1'b0, 1'b0);
    collect(ref_decode(), 3, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_last", {31'd0, out_last}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    randomize_block();
    run_block(1'b0, 1'b0, 1'b0);

    // Back-to-back blocks
    randomize_block();
    run_block(1'b0, 1'b0, 1'b0);
    randomize_block();
    run_block(1'b0, 1'b0, 1'b0);

    for (int b = 0; b < 12; b++) begin
      randomize_block();
      run_block(1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
